alu_seq_unit: RTL and testbench

//  Registered, multi-cycle ALU: the responder side of the a/b/en/opcode/result operand interface.

---
 rtl/alu_seq_unit.sv | 145 ++++++++++++++
 tb/tb_alu_seq_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_unit.sv
// Registered multi-cycle ALU: single-cycle logic/add/compare ops, iterative
// shift-add MUL and restoring DIV taking DW cycles from the accept edge.
module alu_seq_unit #(
    parameter int DW = 16,
    parameter int CW = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DW-1:0]     a,
    input  logic [DW-1:0]     b,
    input  logic              en,
    input  logic [3:0]        opcode,
    output logic [2*DW-1:0]   result,
    output logic              done,
    output logic              busy,
    output logic              err
);

    localparam logic [3:0] OP_ADD  = 4'h0, OP_SUB  = 4'h1, OP_MUL = 4'h2, OP_DIV = 4'h3,
                           OP_AND  = 4'h4, OP_OR   = 4'h5, OP_XOR = 4'h6, OP_NAND = 4'h7,
                           OP_NOR  = 4'h8, OP_XNOR = 4'h9, OP_NOT = 4'hA, OP_SHL = 4'hB,
                           OP_SHR  = 4'hC, OP_EQ   = 4'hD, OP_LT  = 4'hE, OP_GT  = 4'hF;

    typedef enum logic {IDLE, ITER} state_t;

    state_t              state_q;
    logic [CW-1:0]       cnt_q;
    logic                is_div_q;
    logic [2*DW-1:0]     result_q;
    logic                done_q, busy_q, err_q;
    logic [2*DW-1:0]     acc_q;
    logic [2*DW-1:0]     mcand_q;
    logic [DW-1:0]       opa_q;      // MUL: multiplier shifted right; DIV: dividend -> quotient
    logic [DW-1:0]       opb_q;      // DIV divisor
    logic [DW-1:0]       rem_q;

    logic [2*DW-1:0]     a_ext, b_ext, alu_res;
    logic [2*DW-1:0]     mul_acc_d;
    logic [DW:0]         rem_sh, rem_d;
    logic                rem_ge;
    logic [DW-1:0]       quo_d;

    assign a_ext = {{DW{1'b0}}, a};
    assign b_ext = {{DW{1'b0}}, b};

    always_comb begin
        alu_res = '0;
        case (opcode)
            OP_ADD:  alu_res = a_ext + b_ext;
            OP_SUB:  alu_res = a_ext - b_ext;
            OP_AND:  alu_res = {{DW{1'b0}}, a & b};
            OP_OR:   alu_res = {{DW{1'b0}}, a | b};
            OP_XOR:  alu_res = {{DW{1'b0}}, a ^ b};
            OP_NAND: alu_res = {{DW{1'b0}}, ~(a & b)};
            OP_NOR:  alu_res = {{DW{1'b0}}, ~(a | b)};
            OP_XNOR: alu_res = {{DW{1'b0}}, ~(a ^ b)};
            OP_NOT:  alu_res = {{DW{1'b0}}, ~a};
            OP_SHL:  alu_res = a_ext << b[CW-1:0];
            OP_SHR:  alu_res = {{DW{1'b0}}, a >> b[CW-1:0]};
            OP_EQ:   alu_res = {{(2*DW-1){1'b0}}, a == b};
            OP_LT:   alu_res = {{(2*DW-1){1'b0}}, a < b};
            OP_GT:   alu_res = {{(2*DW-1){1'b0}}, a > b};
            default: alu_res = '0;
        endcase
    end

    // One iteration step of each algorithm; only the one matching is_div_q is used.
    always_comb begin
        mul_acc_d = acc_q + (opa_q[0] ? mcand_q : '0);
        rem_sh    = {rem_q, opa_q[DW-1]};
        rem_ge    = rem_sh >= {1'b0, opb_q};
        rem_d     = rem_ge ? (rem_sh - {1'b0, opb_q}) : rem_sh;
        quo_d     = {opa_q[DW-2:0], rem_ge};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            rem_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (en) begin
                        if (opcode == OP_MUL || (opcode == OP_DIV && b != '0)) begin
                            state_q  <= ITER;
                            busy_q   <= 1'b1;
                            cnt_q    <= '0;
                            is_div_q <= (opcode == OP_DIV);
                            acc_q    <= '0;
                            mcand_q  <= a_ext;
                            opa_q    <= (opcode == OP_DIV) ? a : b;
                            opb_q    <= b;
                            rem_q    <= '0;
                        end else if (opcode == OP_DIV) begin
                            result_q <= '1;
                            err_q    <= 1'b1;
                            done_q   <= 1'b1;
                        end else begin
                            result_q <= alu_res;
                            err_q    <= 1'b0;
                            done_q   <= 1'b1;
                        end
                    end
                end
                ITER: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (is_div_q) begin
                        rem_q <= rem_d[DW-1:0];
                        opa_q <= quo_d;
                    end else begin
                        acc_q   <= mul_acc_d;
                        mcand_q <= mcand_q << 1;
                        opa_q   <= opa_q >> 1;
                    end
                    if (cnt_q == CW'(DW-1)) begin
                        result_q <= is_div_q ? {rem_d[DW-1:0], quo_d} : mul_acc_d;
                        err_q    <= 1'b0;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        cnt_q    <= '0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign result = result_q;
    assign done   = done_q;
    assign busy   = busy_q;
    assign err    = err_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed + random bench for alu_seq_unit; expected {err,result} queued at issue
// and compared whenever done pulses.
module tb_alu_seq_unit;
    localparam int DW = 16;
    localparam logic [3:0] ADD = 4'h0, SUB = 4'h1, MUL = 4'h2, DIV = 4'h3,
                           SHL = 4'hB, EQ = 4'hD, LT = 4'hE, GT = 4'hF;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic [15:0]   a = '0, b = '0;
    logic [3:0]    opcode = '0;
    logic [31:0]   result;
    logic          done, busy, err;

    int            checks = 0;
    int            failures = 0;
    logic [32:0]   exp_q[$];
    logic [32:0]   mon_e;
    logic [31:0]   prev;
    int            lat;

    always #5 clk = ~clk;

    alu_seq_unit #(.DW(16), .CW(4)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .en(en), .opcode(opcode),
        .result(result), .done(done), .busy(busy), .err(err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [32:0] model(input logic [3:0] op, input logic [15:0] x, input logic [15:0] y);
        logic [31:0] xl, yl;
        logic [15:0] q, r;
        xl = {16'h0, x};
        yl = {16'h0, y};
        case (op)
            4'h0: return {1'b0, xl + yl};
            4'h1: return {1'b0, xl - yl};
            4'h2: return {1'b0, xl * yl};
            4'h3: begin
                if (y == 16'h0) return {1'b1, 32'hFFFF_FFFF};
                q = x / y;
                r = x % y;
                return {1'b0, r, q};
            end
            4'h4: return {17'h0, x & y};
            4'h5: return {17'h0, x | y};
            4'h6: return {17'h0, x ^ y};
            4'h7: return {17'h0, ~(x & y)};
            4'h8: return {17'h0, ~(x | y)};
            4'h9: return {17'h0, ~(x ^ y)};
            4'hA: return {17'h0, ~x};
            4'hB: return {1'b0, xl << y[3:0]};
            4'hC: return {1'b0, xl >> y[3:0]};
            4'hD: return {32'h0, x == y};
            4'hE: return {32'h0, x < y};
            default: return {32'h0, x > y};
        endcase
    endfunction

    // Scoreboard: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                chk("done_without_issue", done, 1'b0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("sb_result", result, mon_e[31:0]);
                chk("sb_err", err, mon_e[32]);
            end
        end
    end

    // One-cycle en pulse; operands are scrambled right after the accept edge.
    task automatic strobe(input logic [3:0] op, input logic [15:0] x, input logic [15:0] y);
        @(negedge clk);
        opcode = op; a = x; b = y; en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
    endtask

    task automatic wait_done(input int max_cycles, input string tag, output int n);
        n = 0;
        while (!done && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done_seen"}, done, 1'b1);
    endtask

    task automatic issue_wait(input logic [3:0] op, input logic [15:0] x, input logic [15:0] y,
                              input int exp_lat, input string tag);
        int n;
        exp_q.push_back(model(op, x, y));
        strobe(op, x, y);
        wait_done(DW + 2, tag, n);
        chk({tag, "_latency"}, n, exp_lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        #7;
        chk("rst_result", result, 32'h0);
        chk("rst_done", done, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // ADD with carry into upper half
        issue_wait(ADD, 16'hFFFF, 16'h0001, 0, "add");
        chk("add_result", result, 32'h0001_0000);
        chk("add_busy", busy, 1'b0);

        issue_wait(SUB, 16'd3, 16'd5, 0, "sub");
        chk("sub_result", result, 32'hFFFF_FFFE);
        issue_wait(SHL, 16'h8001, 16'd4, 0, "shl");
        chk("shl_result", result, 32'h0008_0010);

        // MUL with an ignored ADD strobe mid-iteration
        prev = result;
        exp_q.push_back(model(MUL, 16'hFFFF, 16'hFFFF));
        strobe(MUL, 16'hFFFF, 16'hFFFF);
        for (int i = 1; i <= 16; i++) begin
            chk("mul_busy", busy, 1'b1);
            chk("mul_no_done", done, 1'b0);
            chk("mul_hold", result, prev);
            if (i == 5) begin
                opcode = ADD; a = 16'd1; b = 16'd1; en = 1'b1;
            end else begin
                en = 1'b0;
            end
            @(negedge clk);
        end
        chk("mul_done", done, 1'b1);
        chk("mul_busy_clear", busy, 1'b0);
        chk("mul_result", result, 32'hFFFE_0001);

        issue_wait(DIV, 16'd100, 16'd7, 16, "div");
        chk("div_result", result, 32'h0002_000E);
        chk("div_err", err, 1'b0);

        // Back-to-back compares, new en on each done cycle
        exp_q.push_back(model(EQ, 16'd5, 16'd5));
        exp_q.push_back(model(LT, 16'd4, 16'd9));
        exp_q.push_back(model(GT, 16'd4, 16'd9));
        @(negedge clk);
        opcode = EQ; a = 16'd5; b = 16'd5; en = 1'b1;
        @(negedge clk);
        chk("b2b_eq_done", done, 1'b1);
        chk("eq_result", result, 32'd1);
        opcode = LT; a = 16'd4; b = 16'd9;
        @(negedge clk);
        chk("b2b_lt_done", done, 1'b1);
        chk("lt_result", result, 32'd1);
        opcode = GT;
        @(negedge clk);
        chk("b2b_gt_done", done, 1'b1);
        chk("gt_result", result, 32'd0);
        en = 1'b0;
        @(negedge clk);
        chk("b2b_done_low", done, 1'b0);

        // Divide by zero: single-cycle error, no iteration
        issue_wait(DIV, 16'd9, 16'd0, 0, "div0");
        chk("div0_result", result, 32'hFFFF_FFFF);
        chk("div0_err", err, 1'b1);
        chk("div0_busy", busy, 1'b0);
        @(negedge clk);
        chk("div0_busy_after", busy, 1'b0);
        chk("div0_done_low", done, 1'b0);

        // Reset in the middle of an iteration discards the op
        strobe(MUL, 16'd300, 16'd200);
        repeat (8) @(negedge clk);
        chk("pre_rst_busy", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_done", done, 1'b0);
        chk("midrst_result", result, 32'h0);
        chk("midrst_err", err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            chk("post_rst_quiet", done | busy, 1'b0);
        end
        issue_wait(MUL, 16'd300, 16'd200, 16, "mul_after_rst");
        chk("mul300_result", result, 32'd60000);

        // Random ops against the model
        for (int i = 0; i < 40; i++) begin
            logic [3:0]  op;
            logic [15:0] x, y;
            op = 4'($urandom_range(0, 15));
            x  = 16'($urandom);
            y  = (i % 4 == 0) ? 16'($urandom_range(0, 17)) : 16'($urandom);
            issue_wait(op, x, y, (op == MUL || (op == DIV && y != 16'h0)) ? 16 : 0, "rand");
        end

        @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
